// File: rtl/pool_stream_buffer.sv
// Streaming 2x2 average pooling: one line buffer holds the even row, and the odd row
// combines with it on the fly to emit one pooled pixel per 2x2 window, with backpressure.
module pool_stream_buffer #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pixel,
  input  logic              out_ready,
  output logic              busy,
  output logic              finish
);

  localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int N_OUT = (IMG_W / 2) * (IMG_H / 2);
  localparam int OW    = $clog2(N_OUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     col, col_m1;
  logic [RW-1:0]     row;
  logic [OW-1:0]     out_cnt;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] linebuf [IMG_W];
  logic [DATA_W-1:0] sum;
  logic              accept, complete, out_fire, all_in, last_out, frame_start;

  // row reaches IMG_H only after the final pixel of the frame has wrapped
  assign all_in   = (row == RW'(IMG_H));
  assign in_ready = (state == RUN) && !all_in && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && row[0] && col[0];
  assign out_fire = out_valid && out_ready;
  assign last_out = (out_cnt == OW'(N_OUT - 1));
  assign col_m1   = col - CW'(1);
  assign sum      = linebuf[col_m1] + linebuf[col] + prev + in_pixel;
  assign busy     = (state != IDLE);
  assign finish   = (state == DONE);

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (out_fire && last_out) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      out_cnt   <= '0;
      prev      <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
    end else begin
      state <= state_next;
      if (frame_start) begin
        col       <= '0;
        row       <= '0;
        out_cnt   <= '0;
        out_valid <= 1'b0;
      end else begin
        if (accept) begin
          if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
          if (row[0] && !col[0]) prev <= in_pixel;
        end
        // a fresh result takes priority so a same-cycle handshake keeps out_valid high
        if (complete) begin
          out_valid <= 1'b1;
          out_pixel <= {2'b00, sum[DATA_W-1:2]};
        end else if (out_fire) begin
          out_valid <= 1'b0;
        end
        if (out_fire) out_cnt <= out_cnt + OW'(1);
      end
    end
  end

  // even-row pixels only; contents are always rewritten before use in a frame
  always_ff @(posedge clk) begin
    if (accept && !row[0]) linebuf[col] <= in_pixel;
  end

endmodule

// File: doc/pool_stream_buffer.md
POOL_STREAM_BUFFER -- requirements
Module: pool_stream_buffer

Interface
REQ-001 Parameter IMG_W, default 28: feature-map width in pixels; even, >= 2.
REQ-002 Parameter IMG_H, default 28: feature-map height in rows; even, >= 2.
REQ-003 Parameter DATA_W, default 16: pixel width in bits.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin one frame; sampled only in IDLE.
REQ-007 in_valid  in  1  upstream pixel valid.
REQ-008 in_pixel  in  DATA_W  upstream pixel, raster order, row-major.
REQ-009 in_ready  out  1  block accepts in_pixel this cycle.
REQ-010 out_valid  out  1  pooled pixel valid.
REQ-011 out_pixel  out  DATA_W  2x2 average-pooled pixel.
REQ-012 out_ready  in  1  downstream accepts out_pixel.
REQ-013 busy  out  1  high in RUN and DONE.
REQ-014 finish  out  1  one-cycle pulse at end of frame.

Function
REQ-015 States: IDLE, RUN, DONE.
REQ-016 IDLE -> RUN when start=1; col, row, and output counters cleared on that transition.
REQ-017 RUN -> DONE on the out_valid&&out_ready handshake of pooled pixel (IMG_H/2)*(IMG_W/2).
REQ-018 DONE -> IDLE after exactly one cycle; finish=1 only in DONE.
REQ-019 Input handshake: pixel accepted iff in_valid && in_ready.
REQ-020 in_ready = (state==RUN) && (not all IMG_W*IMG_H pixels accepted) && (!out_valid || out_ready).
REQ-021 col counts 0..IMG_W-1 per accepted pixel and wraps to 0; row increments on wrap.
REQ-022 Even row: accepted pixel written to line buffer entry col (IMG_W x DATA_W).
REQ-023 Odd row, even col: accepted pixel stored in holding register prev.
REQ-024 Odd row, odd col: sum = linebuf[col-1] + linebuf[col] + prev + in_pixel, each addition modulo 2^DATA_W.
REQ-025 Result on odd row, odd col: out_pixel = {2'b00, sum[DATA_W-1:2]}, i.e. truncating divide by 4 of the wrapped sum, with no rounding.
REQ-026 Latency: out_valid rises the cycle after the completing input handshake.
REQ-027 out_valid and out_pixel hold stable until the out_valid&&out_ready handshake.
REQ-028 Simultaneous events: an output handshake and a new completing input in the same cycle load the new result, and out_valid stays 1.
REQ-029 Backpressure: while out_valid=1 and out_ready=0, in_ready=0, so no pixel is lost or overwritten.
REQ-030 Inputs are ignored in IDLE and DONE; start is ignored in RUN and DONE.
REQ-031 Pooled pixels are emitted in raster order of the output map.

Reset
REQ-032 rst_n=0 asynchronously forces IDLE, counters=0, prev=0, out_valid=0, out_pixel=0, in_ready=0, busy=0, finish=0.
REQ-033 Line buffer contents are not reset and are never read before being written in the current frame.
REQ-034 Reset mid-frame abandons the frame; the next frame requires a new start.

Verification
REQ-035 IMG_W=IMG_H=4, start, pixels 1..16, out_ready=1 -> out_pixel 3,5,11,13 (sums 14,22,46,54), then finish pulse 1 cycle after the 4th handshake.
REQ-036 Pixels 0xFFFF,0xFFFF,0xFFFF,0x0001 in one window -> sum wraps to 0xFFFE, out_pixel=0x3FFF.
REQ-037 Hold out_ready=0 for 10 cycles after the first out_valid -> in_ready=0 throughout, out_pixel stable, no pixels dropped, and final outputs match REQ-035.
REQ-038 Random in_valid/out_ready gaps over a 28x28 frame -> 196 outputs matching the reference model, and exactly one finish.
REQ-039 rst_n pulsed low after pixel 7 of a frame -> all outputs 0 immediately, and a new start plus pixels 1..16 yields the REQ-035 results.
REQ-040 start held high through RUN -> no restart; after DONE with start still high, a new frame begins.
